// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: default sizing,
// controller state encoding and the wavefront-count width rule.
package systolic_pkg;

    localparam int N_DEF       = 4;
    localparam int K_W_DEF     = 8;
    localparam int MUL_LAT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_CLR_WAIT = 3'd2,
        ST_FEED_ON  = 3'd3,
        ST_FEED_GAP = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Wave counts reach k_len + 2N - 2, so one extra bit over the beat
    // field is enough as long as 2N - 2 does not exceed 2**K_W.
    function automatic int wave_width(input int k_w);
        return k_w + 1;
    endfunction

    // Width of the drain counter, which counts 0 .. MUL_LAT-1.
    function automatic int drain_width(input int mul_lat);
        return (mul_lat > 1) ? $clog2(mul_lat) : 1;
    endfunction

endpackage

// File: rtl/systolic_array_sequencer_if.sv
// Control/status bundle between a host and the systolic array sequencer.
interface systolic_array_sequencer_if
    import systolic_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int K_W = K_W_DEF
) ();

    logic             go;
    logic             abort;
    logic [K_W-1:0]   k_len;
    logic             busy;
    logic             done;
    logic             pe_clr;
    logic [2*N-2:0]   pe_start;
    logic [N-1:0]     feed_en;
    logic [K_W:0]     wave_idx;

    modport master (
        output go, abort, k_len,
        input  busy, done, pe_clr, pe_start, feed_en, wave_idx
    );

    modport slave (
        input  go, abort, k_len,
        output busy, done, pe_clr, pe_start, feed_en, wave_idx
    );

endinterface

// File: rtl/sa_wave_decode.sv
// Combinational wavefront decode: for wave w, anti-diagonal d starts (and
// row/column buffer i reads) exactly when 0 <= w - d < k_len.
module sa_wave_decode
    import systolic_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int K_W = K_W_DEF
) (
    input  logic [K_W:0]   wave,
    input  logic [K_W-1:0] k_len,
    input  logic           active,
    output logic [2*N-2:0] pe_start,
    output logic [N-1:0]   feed_en
);

    logic [K_W:0] k_ext;
    assign k_ext = {1'b0, k_len};

    // One window comparator per anti-diagonal.
    for (genvar gi = 0; gi < 2*N-1; gi++) begin : g_diag
        localparam logic [K_W:0] D = (K_W+1)'(gi);
        assign pe_start[gi] = active && (wave >= D) && ((wave - D) < k_ext);
    end

    // Row i and column i are fed on the same skew as diagonal i.
    for (genvar gi = 0; gi < N; gi++) begin : g_feed
        assign feed_en[gi] = pe_start[gi];
    end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Sequencer for an N x N systolic array: clears the PEs, issues skewed
// start/feed wavefronts with a gap cycle between waves, waits for the
// multiplier pipeline to drain and then pulses done.
module systolic_array_sequencer
    import systolic_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int K_W     = K_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    systolic_array_sequencer_if.slave  bus
);

    localparam int WW = wave_width(K_W);
    localparam int DW = drain_width(MUL_LAT);

    state_t          state_reg, state_next;
    logic [K_W-1:0]  k_reg, k_next;
    logic [WW-1:0]   wave_reg, wave_next;
    logic [DW-1:0]   drain_reg, drain_next;

    logic [WW-1:0]   total_waves;
    logic [WW-1:0]   wave_inc;
    logic [2*N-2:0]  pe_start_w;
    logic [N-1:0]    feed_en_w;

    assign total_waves = {1'b0, k_reg} + WW'(2*N-2);
    assign wave_inc    = wave_reg + WW'(1);

    // State and pass context registers; reset discards any pass in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            wave_reg  <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            wave_reg  <= wave_next;
            drain_reg <= drain_next;
        end
    end

    // Next-state logic; abort outranks every normal transition.
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        wave_next  = wave_reg;
        drain_next = drain_reg;

        if (state_reg != ST_IDLE && bus.abort) begin
            state_next = ST_IDLE;
            k_next     = '0;
            wave_next  = '0;
            drain_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.go && !bus.abort) begin
                        k_next     = bus.k_len;
                        wave_next  = '0;
                        drain_next = '0;
                        state_next = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state_next = ST_CLR_WAIT;
                end
                ST_CLR_WAIT: begin
                    state_next = (k_reg == '0) ? ST_DONE : ST_FEED_ON;
                end
                ST_FEED_ON: begin
                    state_next = ST_FEED_GAP;
                end
                ST_FEED_GAP: begin
                    wave_next = wave_inc;
                    if (wave_inc == total_waves) begin
                        drain_next = '0;
                        state_next = (MUL_LAT == 0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        state_next = ST_FEED_ON;
                    end
                end
                ST_DRAIN: begin
                    if (drain_reg == DW'(MUL_LAT-1)) begin
                        state_next = ST_DONE;
                    end else begin
                        drain_next = drain_reg + DW'(1);
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    sa_wave_decode #(
        .N   (N),
        .K_W (K_W)
    ) u_wave_decode (
        .wave     (wave_reg),
        .k_len    (k_reg),
        .active   (state_reg == ST_FEED_ON),
        .pe_start (pe_start_w),
        .feed_en  (feed_en_w)
    );

    // Moore output decode from the registered state only.
    always_comb begin
        bus.busy     = (state_reg != ST_IDLE);
        bus.done     = (state_reg == ST_DONE);
        bus.pe_clr   = (state_reg == ST_CLEAR);
        bus.pe_start = pe_start_w;
        bus.feed_en  = feed_en_w;
        bus.wave_idx = (state_reg == ST_IDLE) ? '0 : wave_reg;
    end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Self-checking bench for systolic_array_sequencer: every cycle of each pass
// is compared against a timeline model derived from the pass length rules.
module tb_systolic_array_sequencer;

    localparam int N  = 4;
    localparam int KW = 8;
    localparam int ML = 8;
    localparam int NS = 2*N-1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_array_sequencer_if #(.N(N), .K_W(KW)) bus ();

    systolic_array_sequencer #(
        .N       (N),
        .K_W     (KW),
        .MUL_LAT (ML)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  32'(bus.busy),     32'd0);
        chk({tag, "_done"},  32'(bus.done),     32'd0);
        chk({tag, "_clr"},   32'(bus.pe_clr),   32'd0);
        chk({tag, "_start"}, 32'(bus.pe_start), 32'd0);
        chk({tag, "_feed"},  32'(bus.feed_en),  32'd0);
        chk({tag, "_wave"},  32'(bus.wave_idx), 32'd0);
    endtask

    function automatic int pass_done_cycle(input int k);
        return (k == 0) ? 3 : 3 + 2*(k + 2*N - 2) + ML;
    endfunction

    // One pass: go presented now (at a negedge in IDLE), cycle 1 is the
    // cycle after the accepting edge. abort_c > 0 raises abort in that cycle.
    task automatic run_pass(input int k, input bit hold_go, input bit change_k, input int abort_c);
        int W, done_c, last, w, done_seen;
        logic [NS-1:0] es;
        logic [N-1:0]  ef;
        bit eb, ed, ec;
        W         = k + 2*N - 2;
        done_c    = pass_done_cycle(k);
        last      = (abort_c > 0) ? abort_c + 4 : done_c + 1;
        done_seen = 0;
        bus.go    = 1'b1;
        bus.abort = 1'b0;
        bus.k_len = KW'(k);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            es = '0;
            ef = '0;
            w  = -1;
            if (abort_c > 0 && c > abort_c) begin
                eb = 0; ed = 0; ec = 0;
            end else begin
                eb = (c <= done_c);
                ed = (c == done_c);
                ec = (c == 1);
                if (k > 0 && c >= 3 && c < 3 + 2*W && ((c - 3) % 2 == 0)) begin
                    w = (c - 3) / 2;
                    for (int d = 0; d < NS; d++)
                        if (w - d >= 0 && w - d < k) es[d] = 1'b1;
                    for (int i = 0; i < N; i++)
                        if (w - i >= 0 && w - i < k) ef[i] = 1'b1;
                end
            end
            chk("busy",     32'(bus.busy),     32'(eb));
            chk("done",     32'(bus.done),     32'(ed));
            chk("pe_clr",   32'(bus.pe_clr),   32'(ec));
            chk("pe_start", 32'(bus.pe_start), 32'(es));
            chk("feed_en",  32'(bus.feed_en),  32'(ef));
            if (w >= 0) chk("wave_idx", 32'(bus.wave_idx), 32'(w));
            if (abort_c > 0 && c > abort_c) chk("wave_after_abort", 32'(bus.wave_idx), 32'd0);
            if (bus.done === 1'b1) done_seen++;
            if (!hold_go) bus.go = 1'b0;
            if (change_k) bus.k_len = KW'($urandom);
            bus.abort = (c == abort_c);
        end
        chk("done_count", 32'(done_seen), (abort_c > 0) ? 32'd0 : 32'd1);
        bus.go    = 1'b0;
        bus.abort = 1'b0;
        $display("pass k=%0d hold_go=%0d change_k=%0d abort_cycle=%0d done_cycle=%0d dones=%0d",
                 k, hold_go, change_k, abort_c, done_c, done_seen);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        int k, ab, dc, seen;
        bit hg, ck;
        rst_n     = 1'b0;
        bus.go    = 1'b0;
        bus.abort = 1'b0;
        bus.k_len = '0;
        #2;
        chk_idle_outputs("reset_async");
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset_hold");
        rst_n = 1'b1;
        idle_cycles(2);

        // Directed passes; consecutive calls also cover go with no dead cycle.
        run_pass(1, 0, 0, 0);
        run_pass(3, 0, 0, 0);
        run_pass(0, 0, 0, 0);
        run_pass(3, 0, 0, 10);
        run_pass(3, 0, 0, 0);
        run_pass(5, 1, 1, 0);
        run_pass(2, 1, 0, 0);
        idle_cycles(1);

        // go and abort together in IDLE are refused.
        bus.go    = 1'b1;
        bus.abort = 1'b1;
        bus.k_len = KW'(2);
        @(negedge clk);
        chk_idle_outputs("go_abort_idle");
        bus.go    = 1'b0;
        bus.abort = 1'b0;
        idle_cycles(1);

        // Asynchronous reset in the middle of the feed phase.
        bus.go    = 1'b1;
        bus.k_len = KW'(3);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            bus.go = 1'b0;
        end
        chk("pre_reset_feed", 32'(bus.feed_en), 32'b0111);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid_feed_reset");
        @(posedge clk);
        #2;
        chk_idle_outputs("mid_feed_reset_edge");
        #6;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        chk("no_resume_after_reset", 32'(seen), 32'd0);
        $display("reset mid-pass: cycles active after release=%0d", seen);

        // Randomised passes with random holds, k_len churn and aborts.
        for (int t = 0; t < 20; t++) begin
            k  = $urandom_range(0, 12);
            dc = pass_done_cycle(k);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dc - 1) : 0;
            hg = (ab == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            ck = 1'($urandom_range(0, 1));
            run_pass(k, hg, ck, ab);
            idle_cycles($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
